// File: rtl/synth_pkg.sv
// Shared widths, default envelope values, register field map and scheduler states.
// Used by the voice sequencer top and its mix/saturate accumulator.
package synth_pkg;

  localparam int BITDEPTH  = 14;
  localparam int ACC_GUARD = 4;

  localparam logic [7:0] DEF_ATTACK = 8'hf0;
  localparam logic [7:0] DEF_DECAY  = 8'h40;

  localparam int CFG_BIT  = 31;
  localparam int TUNE_LSB = 24;
  localparam int ATK_LSB  = 16;
  localparam int DEC_LSB  = 8;
  localparam int NOTE_LSB = 1;
  localparam int GATE_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [6:0] tuning;
    logic [7:0] attack;
    logic [7:0] decay;
    logic [6:0] note;
    logic       gate;
  } voice_t;

  // Unconfigured slots run on default envelope and no detune; note/gate always pass through.
  function automatic voice_t slot_to_voice(input logic [31:0] w,
                                           input logic [7:0]  def_att,
                                           input logic [7:0]  def_dec);
    voice_t v;
    v.note = w[NOTE_LSB +: 7];
    v.gate = w[GATE_BIT];
    if (w[CFG_BIT]) begin
      v.tuning = w[TUNE_LSB +: 7];
      v.attack = w[ATK_LSB +: 8];
      v.decay  = w[DEC_LSB +: 8];
    end else begin
      v.tuning = '0;
      v.attack = def_att;
      v.decay  = def_dec;
    end
    return v;
  endfunction

endpackage

// File: rtl/synth_mix_sat.sv
// Frame mix accumulator: adds sign-extended voice samples, then shifts and saturates.
// o_mix_nxt already includes the sample being added this cycle, so the caller can register it directly.
module synth_mix_sat #(
  parameter int BITDEPTH  = synth_pkg::BITDEPTH,
  parameter int MIX_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_add,
  input  logic [BITDEPTH-1:0] i_sample,
  output logic [BITDEPTH-1:0] o_mix_nxt
);
  import synth_pkg::*;

  localparam int AW = BITDEPTH + ACC_GUARD;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (BITDEPTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_sext;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_shift;

  assign w_sext  = i_add ? {{ACC_GUARD{i_sample[BITDEPTH-1]}}, i_sample} : '0;
  assign w_sum   = r_acc + w_sext;
  assign w_shift = w_sum >>> MIX_SHIFT;

  always_comb begin
    o_mix_nxt = w_shift[BITDEPTH-1:0];
    if (w_shift > SAT_MAX) begin
      o_mix_nxt = SAT_MAX[BITDEPTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      o_mix_nxt = SAT_MIN[BITDEPTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/synth_voice_sequencer.sv
// Voice slot registers plus a per-tick scheduler over one shared voice datapath; mix_valid one cycle after the last v_done.
// SYNTH_SEQ_TIMEOUT_EN adds a 255-cycle WAIT watchdog whose sticky flag reads back on data_out[31] at addr 0.
module synth_voice_sequencer #(
  parameter int         NUM_VOICES = 16,
  parameter int         BITDEPTH   = synth_pkg::BITDEPTH,
  parameter int         MIX_SHIFT  = 2,
  parameter logic [7:0] DEF_ATTACK = synth_pkg::DEF_ATTACK,
  parameter logic [7:0] DEF_DECAY  = synth_pkg::DEF_DECAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          addr,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  input  logic                wen,
  input  logic                ren,
  output logic                ready,
  input  logic                sample_tick,
  output logic                v_start,
  output logic [3:0]          v_index,
  output logic [6:0]          v_tuning,
  output logic [7:0]          v_attack,
  output logic [7:0]          v_decay,
  output logic [6:0]          v_note,
  output logic                v_gate,
  input  logic                v_done,
  input  logic [BITDEPTH-1:0] v_sample,
  output logic [BITDEPTH-1:0] mix_out,
  output logic                mix_valid,
  output logic                overrun
);
  import synth_pkg::*;

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [31:0]         r_slot [16];
  logic [3:0]          r_idx;
  logic [3:0]          r_v_index;
  voice_t              r_voice;
  logic                r_v_start;
  logic                r_mix_valid;
  logic [BITDEPTH-1:0] r_mix_out;
  logic [BITDEPTH-1:0] w_mix_nxt;
  logic                r_ready_q;
  logic [31:0]         r_data_out;
  logic [31:0]         w_rd_dat;
  logic                w_addr_ok;
  logic                w_last;
  logic                w_slot_done;
  logic                w_acc_clr;
  logic                w_acc_add;

  assign w_addr_ok = ({28'd0, addr} < 32'(NUM_VOICES));
  assign w_last    = (r_idx == 4'(NUM_VOICES - 1));

`ifdef SYNTH_SEQ_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout_flag;
  logic       w_timeout;

  // Counter value k means k cycles have elapsed since v_start.
  assign w_timeout   = (r_state == ST_WAIT) && !v_done && (r_wdog == 8'hff);
  assign w_slot_done = v_done | w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog         <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_wdog <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign w_slot_done = v_done;
`endif

  always_comb begin
    w_rd_dat = '0;
    if (w_addr_ok) begin
      w_rd_dat = r_slot[addr];
    end
`ifdef SYNTH_SEQ_TIMEOUT_EN
    if (addr == 4'd0) begin
      w_rd_dat[CFG_BIT] = r_timeout_flag;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        r_slot[i] <= '0;
      end
      r_ready_q  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ready_q <= wen | ren;
      if (wen && w_addr_ok) begin
        r_slot[addr] <= data_in;
      end
      if (ren) begin
        r_data_out <= w_rd_dat;
      end
    end
  end

  assign ready    = r_ready_q & (wen | ren);
  assign data_out = r_data_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_clr   = 1'b0;
    w_acc_add   = 1'b0;
    overrun     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_state_nxt = ST_LOAD;
          w_acc_clr   = 1'b1;
        end
      end
      ST_LOAD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_acc_add = v_done;
        if (w_slot_done) begin
          w_state_nxt = w_last ? ST_OUT : ST_LOAD;
        end
      end
      ST_OUT:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (sample_tick && (r_state != ST_IDLE)) begin
      overrun = 1'b1;
    end
  end

  // mix_out is captured on the final handshake so it is already valid during OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= '0;
      r_v_index   <= '0;
      r_voice     <= '0;
      r_v_start   <= 1'b0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_v_start   <= 1'b0;
      r_mix_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_idx <= '0;
          end
        end
        ST_LOAD: begin
          r_voice   <= slot_to_voice(r_slot[r_idx], DEF_ATTACK, DEF_DECAY);
          r_v_index <= r_idx;
          r_v_start <= 1'b1;
        end
        ST_WAIT: begin
          if (w_slot_done) begin
            if (w_last) begin
              r_mix_out   <= w_mix_nxt;
              r_mix_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  synth_mix_sat #(
    .BITDEPTH  (BITDEPTH),
    .MIX_SHIFT (MIX_SHIFT)
  ) u_mix (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_acc_clr),
    .i_add     (w_acc_add),
    .i_sample  (v_sample),
    .o_mix_nxt (w_mix_nxt)
  );

  assign v_start   = r_v_start;
  assign v_index   = r_v_index;
  assign v_tuning  = r_voice.tuning;
  assign v_attack  = r_voice.attack;
  assign v_decay   = r_voice.decay;
  assign v_note    = r_voice.note;
  assign v_gate    = r_voice.gate;
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;

endmodule

// File: tb/tb_synth_voice_sequencer.sv
// Bench for synth_voice_sequencer: a datapath responder, a per-cycle frame/overrun/mix model, and directed CPU/frame vectors.
module tb_synth_voice_sequencer;

  localparam int NV    = 4;
  localparam int BD    = 14;
  localparam int SHIFT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic          ready;
  logic          sample_tick = 1'b0;
  logic          v_start;
  logic [3:0]    v_index;
  logic [6:0]    v_tuning;
  logic [7:0]    v_attack;
  logic [7:0]    v_decay;
  logic [6:0]    v_note;
  logic          v_gate;
  logic          v_done = 1'b0;
  logic [BD-1:0] v_sample = '0;
  logic [BD-1:0] mix_out;
  logic          mix_valid;
  logic          overrun;

  synth_voice_sequencer #(
    .NUM_VOICES (NV),
    .BITDEPTH   (BD),
    .MIX_SHIFT  (SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .wen         (wen),
    .ren         (ren),
    .ready       (ready),
    .sample_tick (sample_tick),
    .v_start     (v_start),
    .v_index     (v_index),
    .v_tuning    (v_tuning),
    .v_attack    (v_attack),
    .v_decay     (v_decay),
    .v_note      (v_note),
    .v_gate      (v_gate),
    .v_done      (v_done),
    .v_sample    (v_sample),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_regs [NV];
  int          samples [NV];
  int          resp_delay = 2;
  int          withhold = -1;
  int          frame_sum = 0;
  int          resp_slot = 0;
  int          resp_cnt = 0;
  bit          pending = 1'b0;
  bit          busy = 1'b0;
  bit          prev_last = 1'b0;
  int          exp_slot = 0;
  logic [31:0] chk_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat_mix(input int s);
    int q;
    q = s >>> SHIFT;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  // Voice datapath stand-in: answers each v_start after resp_delay+1 cycles with samples[slot].
  always @(posedge clk) begin
    #1;
    v_done = 1'b0;
    if (!rst) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (resp_cnt == 0) begin
          v_done    = 1'b1;
          v_sample  = BD'(samples[resp_slot[1:0]]);
          frame_sum = frame_sum + samples[resp_slot[1:0]];
          pending   = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
      if (v_start && !pending && (int'(v_index) != withhold)) begin
        pending   = 1'b1;
        resp_cnt  = resp_delay;
        resp_slot = int'(v_index);
      end
    end
  end

  // Frame model: slots visited in order, mix = sat(sum >>> SHIFT) one cycle after the last answer,
  // ticks are dropped (overrun) from the cycle after acceptance through the mix_valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      busy      = 1'b0;
      prev_last = 1'b0;
      exp_slot  = 0;
    end else begin
      check("overrun", overrun, sample_tick && busy);
      check("mix_valid", mix_valid, prev_last);
      if (v_start) begin
        chk_w = model_regs[exp_slot[1:0]];
        check("v_index", v_index, exp_slot);
        check("v_tuning", v_tuning, chk_w[31] ? chk_w[30:24] : 7'd0);
        check("v_attack", v_attack, chk_w[31] ? chk_w[23:16] : 8'hf0);
        check("v_decay", v_decay, chk_w[31] ? chk_w[15:8] : 8'h40);
        check("v_note", v_note, chk_w[7:1]);
        check("v_gate", v_gate, chk_w[0]);
        exp_slot++;
      end
      if (mix_valid) begin
        check("mix_out", int'(signed'(mix_out)), sat_mix(frame_sum));
        frame_sum = 0;
        exp_slot  = 0;
        busy      = 1'b0;
      end else if (sample_tick && !busy) begin
        busy = 1'b1;
      end
      prev_last = v_done && (resp_slot == NV - 1);
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; data_in = d; wen = 1'b1;
    @(negedge clk);
    check("wr_ready_c1", ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_ready_c2", ready, 1'b1);
    @(posedge clk); #1;
    wen = 1'b0;
    if (a < NV) model_regs[a[1:0]] = d;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    addr = a; ren = 1'b1;
    @(negedge clk);
    check("rd_ready_c1", ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_ready_c2", ready, 1'b1);
    d = data_out;
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_mix(input int budget, output int m);
    bit got;
    got = 1'b0;
    m = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (mix_valid) begin
        got = 1'b1;
        m = int'(signed'(mix_out));
      end
    end
    check("mix_seen", got, 1'b1);
  endtask

  task automatic count_mix(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mix_valid) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] rd;
    int          m;
    int          n;
    bit          got;

    for (int i = 0; i < NV; i++) begin
      model_regs[i] = '0;
      samples[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_mix_out", mix_out, '0);
    check("rst_mix_valid", mix_valid, 1'b0);
    check("rst_v_start", v_start, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_v_attack", v_attack, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;

    cpu_write(4'd3, 32'h0000_0079);
    cpu_read(4'd3, rd);
    check("rd_slot3", rd, 32'h0000_0079);
    cpu_write(4'd7, 32'hdead_beef);
    cpu_read(4'd7, rd);
    check("rd_addr7", rd, 32'h0);
    cpu_write(4'd0, 32'h5511_2215);
    cpu_write(4'd1, 32'h9234_5678);
    cpu_read(4'd1, rd);
    check("rd_slot1", rd, 32'h9234_5678);

    // Frame 1: slot 0 is unconfigured, so defaults must be presented.
    samples = '{1000, 2000, -500, 100};
    resp_delay = 2;
    pulse_tick();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (v_start) got = 1'b1;
    end
    check("vstart_seen", got, 1'b1);
    check("slot0_index", v_index, 4'd0);
    check("slot0_attack", v_attack, 8'hf0);
    check("slot0_decay", v_decay, 8'h40);
    check("slot0_tuning", v_tuning, 7'd0);
    check("slot0_note", v_note, 7'h0a);
    wait_mix(200, m);
    check("mix_650", m, 650);

    samples = '{8191, 8191, 8191, 8191};
    pulse_tick();
    wait_mix(200, m);
    check("mix_pos_max", m, 8191);

    samples = '{-8192, -8192, -8192, -8192};
    resp_delay = 0;
    pulse_tick();
    wait_mix(200, m);
    check("mix_neg_min", m, -8192);

    // Second tick during WAIT is dropped.
    samples = '{1, 2, 3, 4};
    resp_delay = 6;
    pulse_tick();
    repeat (3) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(negedge clk);
    check("overrun_pulse", overrun, 1'b1);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    count_mix(120, n);
    check("one_mix_per_frame", n, 1);

    // Reset mid-frame aborts it and clears the slot bank.
    samples = '{100, 100, 100, 100};
    resp_delay = 4;
    pulse_tick();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    frame_sum = 0;
    for (int i = 0; i < NV; i++) model_regs[i] = '0;
    @(negedge clk);
    check("abort_v_start", v_start, 1'b0);
    check("abort_mix_valid", mix_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    count_mix(40, n);
    check("abort_no_mix", n, 0);

    samples = '{10, 20, 30, 40};
    resp_delay = 1;
    pulse_tick();
    wait_mix(200, m);
    check("mix_after_reset", m, 25);

`ifdef SYNTH_SEQ_TIMEOUT_EN
    samples = '{400, 999, 800, -200};
    withhold = 1;
    pulse_tick();
    wait_mix(1500, m);
    check("mix_timeout_slot", m, 250);
    withhold = -1;
    cpu_read(4'd0, rd);
    check("timeout_flag", rd[31], 1'b1);
`else
    cpu_write(4'd0, 32'h8000_0000);
    cpu_read(4'd0, rd);
    check("rd_slot0_cfg", rd, 32'h8000_0000);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
